// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command-frame parser.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StCsum,
        StCommit
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'b000;
    localparam logic [2:0] ERR_CSUM    = 3'b001;
    localparam logic [2:0] ERR_LINE    = 3'b010;
    localparam logic [2:0] ERR_TIMEOUT = 3'b011;
    localparam logic [2:0] ERR_ADDR    = 3'b100;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-write output bundle of the command parser.
interface uart_cmd_parser_if #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_W     = 4
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic                    rx_parity_err;
    logic                    rx_frame_err;
    logic [ADDR_W-1:0]       reg_addr;
    logic [8*DATA_BYTES-1:0] reg_wdata;
    logic                    reg_wr;
    logic                    cmd_err;
    logic [2:0]              err_code;
    logic                    busy;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err,
        input  reg_addr, reg_wdata, reg_wr, cmd_err, err_code, busy
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err,
        output reg_addr, reg_wdata, reg_wr, cmd_err, err_code, busy
    );
endinterface

// File: rtl/uart_timeout_cnt.sv
// Inter-byte watchdog: counts enabled idle cycles, pulses tc on the cycle that reaches the limit.
module uart_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // A clear in the terminal cycle suppresses the pulse, so an arriving byte wins.
    assign tc = en & ~clr & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles sync/addr/payload/xor-checksum frames from received bytes into register writes.
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned ADDR_W         = 4,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic              clk,
    input logic              rst_n,
    uart_cmd_parser_if.slave bus
);
    localparam int unsigned DW = 8 * DATA_BYTES;

    state_e            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [7:0]        csum_q, csum_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DW-1:0]     reg_wdata_q, reg_wdata_d;
    logic              reg_wr_q, reg_wr_d;
    logic              cmd_err_q, cmd_err_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              line_err, in_frame, tmo, fail;
    logic [2:0]        fail_code;

    assign line_err = bus.rx_parity_err | bus.rx_frame_err;
    assign in_frame = state_q inside {StAddr, StData, StCsum};

    uart_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (bus.rx_valid | ~in_frame),
        .en   (in_frame),
        .tc   (tmo)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        csum_d      = csum_q;
        byte_cnt_d  = byte_cnt_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        cmd_err_d   = 1'b0;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        unique case (state_q)
            StIdle, StCommit: begin
                if (state_q == StCommit) begin
                    reg_addr_d  = addr_q[ADDR_W-1:0];
                    reg_wdata_d = data_q;
                    reg_wr_d    = 1'b1;
                    state_d     = StIdle;
                end
                if (bus.rx_valid && !line_err && bus.rx_data == SYNC_BYTE) begin
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (bus.rx_valid) begin
                    addr_d     = bus.rx_data;
                    csum_d     = bus.rx_data;
                    byte_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (bus.rx_valid) begin
                    data_d = (data_q << 8) | DW'(bus.rx_data);
                    csum_d = csum_q ^ bus.rx_data;
                    if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
                        state_d = StCsum;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            StCsum: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data != csum_q) begin
                        fail      = 1'b1;
                        fail_code = ERR_CSUM;
                    end else if ((addr_q >> ADDR_W) != 8'd0) begin
                        fail      = 1'b1;
                        fail_code = ERR_ADDR;
                    end else begin
                        state_d = StCommit;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Line errors and timeouts override whatever the in-frame state decided.
        if (in_frame) begin
            if (bus.rx_valid && line_err) begin
                fail      = 1'b1;
                fail_code = ERR_LINE;
            end else if (tmo) begin
                fail      = 1'b1;
                fail_code = ERR_TIMEOUT;
            end
        end

        if (fail) begin
            state_d    = StIdle;
            cmd_err_d  = 1'b1;
            err_code_d = fail_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            data_q      <= '0;
            csum_q      <= '0;
            byte_cnt_q  <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            csum_q      <= csum_d;
            byte_cnt_q  <= byte_cnt_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            cmd_err_q   <= cmd_err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
